// File: rtl/booth_mul64_ctrl_pkg.sv
// rtl/booth_mul64_ctrl_pkg.sv - shared widths and state encoding for the Booth multiplier
package booth_mul64_ctrl_pkg;

    localparam int OP_W   = 64;
    localparam int ADD_W  = 65;
    localparam int PROD_W = 128;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cla65.sv
// rtl/cla65.sv - 65-bit adder built from 16 cascaded 4-bit look-ahead blocks plus a top full adder
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        sum  = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module cla65 (
    input  logic [64:0] a,
    input  logic [64:0] b,
    input  logic        ci,
    output logic [64:0] sum
);
    logic [16:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 16; i++) begin : g_blk
        cla4 u_cla4 (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .ci  (c[i]),
            .sum (sum[4*i +: 4]),
            .co  (c[i+1])
        );
    end

    // Top bit only needs its sum; the final carry-out is never consumed.
    assign sum[64] = a[64] ^ b[64] ^ c[16];
endmodule

// File: rtl/booth_mul64_ctrl.sv
// rtl/booth_mul64_ctrl.sv - sequential radix-2 Booth 64x64 signed multiplier sharing one cla65
module booth_mul64_ctrl
    import booth_mul64_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                op_start,
    input  logic                op_clear,
    input  logic [OP_W-1:0]     multiplicand,
    input  logic [OP_W-1:0]     multiplier,
    output logic                op_busy,
    output logic                op_done,
    output logic [PROD_W-1:0]   result
);
    state_t             state;
    state_t             state_next;
    logic [OP_W-1:0]    m_reg;
    logic [OP_W-1:0]    q_reg;
    logic [ADD_W-1:0]   acc;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;

    logic [ADD_W-1:0]   add_b;
    logic               add_ci;
    logic [ADD_W-1:0]   sum;
    logic [ADD_W-1:0]   m_ext;

    assign m_ext = {m_reg[OP_W-1], m_reg};

    // Booth pair {Q[0], q_m1}: 01 adds M, 10 subtracts M via invert plus carry-in.
    always_comb begin
        add_b  = '0;
        add_ci = 1'b0;
        case ({q_reg[0], q_m1})
            2'b01: add_b = m_ext;
            2'b10: begin
                add_b  = ~m_ext;
                add_ci = 1'b1;
            end
            default: ;
        endcase
    end

    cla65 u_cla65 (
        .a   (acc),
        .b   (add_b),
        .ci  (add_ci),
        .sum (sum)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (op_start && !op_clear) state_next = ST_EXEC;
            ST_EXEC: begin
                if (op_clear)
                    state_next = ST_IDLE;
                else if (cnt == CNT_W'(OP_W - 1))
                    state_next = ST_DONE;
            end
            ST_DONE: if (op_clear) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            m_reg <= '0;
            q_reg <= '0;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (op_start && !op_clear) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_EXEC: begin
                    if (!op_clear) begin
                        acc   <= {sum[ADD_W-1], sum[ADD_W-1:1]};
                        q_reg <= {sum[0], q_reg[OP_W-1:1]};
                        q_m1  <= q_reg[0];
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_busy = (state == ST_EXEC);
    assign op_done = (state == ST_DONE);
    assign result  = (state == ST_DONE) ? {acc[OP_W-1:0], q_reg} : '0;

endmodule

// File: tb/tb_booth_mul64_ctrl.sv
// tb/tb_booth_mul64_ctrl.sv - randomized self-checking bench for booth_mul64_ctrl
module tb_booth_mul64_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_start;
    logic         op_clear;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic         op_busy;
    logic         op_done;
    logic [127:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    booth_mul64_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .result       (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] x;
        logic signed [127:0] y;
        x = $signed({{64{a[63]}}, a});
        y = $signed({{64{b[63]}}, b});
        return x * y;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 128'(op_busy), 128'd0);
        check({tag, "_done"}, 128'(op_done), 128'd0);
        check({tag, "_res"}, result, 128'd0);
    endtask

    task automatic start_op(input logic [63:0] m, input logic [63:0] q);
        op_start     = 1'b1;
        multiplicand = m;
        multiplier   = q;
        step(1);
        t0           = cyc;
        op_start     = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        check("busy_after_start", 128'(op_busy), 128'd1);
    endtask

    task automatic wait_done(input string tag, input logic [127:0] exp);
        while (!op_done && (cyc - t0) < 200) step(1);
        check({tag, "_lat"}, 128'(cyc - t0), 128'd64);
        check({tag, "_res"}, result, exp);
    endtask

    task automatic clear_op();
        op_clear = 1'b1;
        step(1);
        op_clear = 1'b0;
        check_idle("clear");
    endtask

    task automatic full_op(input string tag, input logic [63:0] m, input logic [63:0] q,
                           input logic [127:0] exp);
        start_op(m, q);
        wait_done(tag, exp);
        clear_op();
    endtask

    logic [63:0]  rm;
    logic [63:0]  rq;
    logic [127:0] held;

    initial begin
        reset = 1'b1;
        op_start = 1'b0;
        op_clear = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        step(2);
        check_idle("reset");
        reset = 1'b0;
        step(1);

        full_op("pos", 64'd3, 64'd5, 128'd15);
        full_op("mixed", -64'sd7, 64'd6, -128'sd42);
        full_op("negneg", -64'sd1, -64'sd1, 128'd1);
        full_op("minmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                {2'b01, 126'd0});
        full_op("minone", 64'h8000_0000_0000_0000, 64'd1, {{65{1'b1}}, 63'd0});

        for (int i = 0; i < 12; i++) begin
            rm = {$urandom, $urandom};
            rq = {$urandom, $urandom};
            if (i == 0) rm = 64'h7FFF_FFFF_FFFF_FFFF;
            if (i == 1) rq = 64'h8000_0000_0000_0000;
            full_op("rand", rm, rq, ref_mul(rm, rq));
        end

        // start pulse mid-run with other operands must not disturb the product
        rm = {$urandom, $urandom};
        rq = {$urandom, $urandom};
        start_op(rm, rq);
        step(19);
        op_start = 1'b1;
        multiplicand = 64'd11;
        multiplier = 64'd13;
        step(1);
        op_start = 1'b0;
        wait_done("ign_start", ref_mul(rm, rq));
        held = result;
        op_start = 1'b1;
        multiplicand = 64'd2;
        multiplier = 64'd2;
        step(5);
        check("done_hold", 128'(op_done), 128'd1);
        check("done_hold_res", result, held);
        check("done_hold_busy", 128'(op_busy), 128'd0);
        op_start = 1'b0;
        clear_op();

        // abort at iteration 10
        start_op({$urandom, $urandom}, {$urandom, $urandom});
        step(9);
        op_clear = 1'b1;
        step(1);
        op_clear = 1'b0;
        check_idle("abort");
        step(3);
        check_idle("abort_stay");
        full_op("after_abort", 64'd2, 64'd3, 128'd6);

        // reset mid-run at iteration 40
        start_op(64'd123, 64'd456);
        step(39);
        reset = 1'b1;
        step(1);
        check_idle("rst_mid");
        reset = 1'b0;
        step(70);
        check_idle("rst_mid_stay");

        reset = 1'b1;
        op_start = 1'b1;
        step(1);
        reset = 1'b0;
        op_start = 1'b0;
        check_idle("rst_start");

        op_start = 1'b1;
        op_clear = 1'b1;
        step(1);
        op_start = 1'b0;
        op_clear = 1'b0;
        check_idle("start_clear");

        full_op("final", -64'sd5, 64'd9, -128'sd45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
